// File: rtl/ar_xbar_arbiter.sv
// ar_xbar_arbiter
//   Round-robin arbiter sharing one slave-side AXI AR channel among
//   NUM_MASTERS per-master AR request FIFOs. The winning FIFO is popped and
//   its request is registered into a valid/ready output stage. ARID is
//   prefixed with the master index so the R path can route responses back.
//
//   Optional feature macro: AR_XBAR_ARB_PENDING_LIMIT_EN
//     defined   -> grants are throttled while pending_cnt >= MAX_PENDING
//     undefined -> no limit; pending_cnt tied to 0; R inputs ignored
//
//   Ports
//     clk, rst                      clock, async active-high reset
//     fifo_empty / fifo_pop         per-FIFO empty flag / one-hot pop
//     fifo_AR{ID,ADDR,LEN,SIZE,BURST} packed FIFO fronts, master i at slice i
//     AR{ID,ADDR,LEN,SIZE,BURST}_S  registered request; ARID_S = {idx, ARID}
//     ARVALID_S / ARREADY_S         output handshake
//     RVALID_S, RREADY_S, RLAST_S   R handshake, used for the pending count
//     pending_cnt                   outstanding reads
//     grant_idx                     index of the last granted master
module ar_xbar_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 4,
  parameter int SIZE_WIDTH  = 3,
  parameter int MAX_PENDING = 8,
  localparam int MIDX_W     = $clog2(NUM_MASTERS),
  localparam int CNT_W      = $clog2(MAX_PENDING+1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            fifo_empty,
  output logic [NUM_MASTERS-1:0]            fifo_pop,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   fifo_ARID,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] fifo_ARADDR,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  fifo_ARLEN,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0] fifo_ARSIZE,
  input  logic [NUM_MASTERS*2-1:0]          fifo_ARBURST,
  output logic [MIDX_W+ID_WIDTH-1:0]        ARID_S,
  output logic [ADDR_WIDTH-1:0]             ARADDR_S,
  output logic [LEN_WIDTH-1:0]              ARLEN_S,
  output logic [SIZE_WIDTH-1:0]             ARSIZE_S,
  output logic [1:0]                        ARBURST_S,
  output logic                              ARVALID_S,
  input  logic                              ARREADY_S,
  input  logic                              RVALID_S,
  input  logic                              RREADY_S,
  input  logic                              RLAST_S,
  output logic [CNT_W-1:0]                  pending_cnt,
  output logic [MIDX_W-1:0]                 grant_idx
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e state_q, state_d;

  // Packed views of the flattened FIFO fronts: slice i is master i.
  logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]   id_a;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_MASTERS-1:0][LEN_WIDTH-1:0]  len_a;
  logic [NUM_MASTERS-1:0][SIZE_WIDTH-1:0] size_a;
  logic [NUM_MASTERS-1:0][1:0]            burst_a;

  assign id_a    = fifo_ARID;
  assign addr_a  = fifo_ARADDR;
  assign len_a   = fifo_ARLEN;
  assign size_a  = fifo_ARSIZE;
  assign burst_a = fifo_ARBURST;

  logic [MIDX_W-1:0]          rr_q, rr_d, win, gidx_q;
  logic [MIDX_W+ID_WIDTH-1:0] arid_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [SIZE_WIDTH-1:0]      size_q;
  logic [1:0]                 burst_q;
  logic                       found, limit_ok, stage_free, grant;

  // Round-robin search: first non-empty index at or after rr_q, wrapping.
  always_comb begin
    logic [MIDX_W:0] sum;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      sum = {1'b0, rr_q} + (MIDX_W+1)'(k);
      if (sum >= (MIDX_W+1)'(NUM_MASTERS)) sum = sum - (MIDX_W+1)'(NUM_MASTERS);
      if (!found && !fifo_empty[sum[MIDX_W-1:0]]) begin
        found = 1'b1;
        win   = sum[MIDX_W-1:0];
      end
    end
  end

  assign rr_d = (win == MIDX_W'(NUM_MASTERS-1)) ? '0 : win + 1'b1;

`ifdef AR_XBAR_ARB_PENDING_LIMIT_EN
  logic [CNT_W-1:0] pend_q;
  logic             r_done;

  // Registered count only: an RLAST in this cycle frees a slot next cycle.
  assign limit_ok = (pend_q < CNT_W'(MAX_PENDING));
  assign r_done   = RVALID_S & RREADY_S & RLAST_S & (pend_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pend_q <= '0;
    else if (grant & ~r_done) pend_q <= pend_q + 1'b1;
    else if (~grant & r_done) pend_q <= pend_q - 1'b1;
  end

  assign pending_cnt = pend_q;
`else
  logic unused_r;
  assign unused_r    = RVALID_S & RREADY_S & RLAST_S;
  assign limit_ok    = 1'b1;
  assign pending_cnt = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   if (ARREADY_S && !grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. grant feeds only flops that are held in reset anyway; the
  // visible pop is additionally masked so nothing is popped during reset.
  always_comb begin
    ARVALID_S  = (state_q == ISSUE);
    stage_free = ~ARVALID_S | ARREADY_S;
    grant      = stage_free & found & limit_ok;
    fifo_pop   = '0;
    if (grant && !rst) fifo_pop[win] = 1'b1;
  end

  // Request register and arbitration pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arid_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
    end else if (grant) begin
      arid_q  <= {win, id_a[win]};
      addr_q  <= addr_a[win];
      len_q   <= len_a[win];
      size_q  <= size_a[win];
      burst_q <= burst_a[win];
      gidx_q  <= win;
      rr_q    <= rr_d;
    end
  end

  assign ARID_S    = arid_q;
  assign ARADDR_S  = addr_q;
  assign ARLEN_S   = len_q;
  assign ARSIZE_S  = size_q;
  assign ARBURST_S = burst_q;
  assign grant_idx = gidx_q;

endmodule

// File: tb/tb_ar_xbar_arbiter.sv
module tb_ar_xbar_arbiter;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ent_t;

  logic             clk, rst;
  logic [3:0]       fifo_empty, fifo_pop;
  logic [3:0][3:0]  f_id;
  logic [3:0][31:0] f_addr;
  logic [3:0][3:0]  f_len;
  logic [3:0][2:0]  f_size;
  logic [3:0][1:0]  f_burst;
  logic [5:0]       ARID_S;
  logic [31:0]      ARADDR_S;
  logic [3:0]       ARLEN_S;
  logic [2:0]       ARSIZE_S;
  logic [1:0]       ARBURST_S;
  logic             ARVALID_S, ARREADY_S, RVALID_S, RREADY_S, RLAST_S;
  logic [1:0]       pending_cnt;
  logic [1:0]       grant_idx;

  ar_xbar_arbiter #(.NUM_MASTERS(4), .ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(4),
                    .SIZE_WIDTH(3), .MAX_PENDING(2)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_ARID(f_id), .fifo_ARADDR(f_addr), .fifo_ARLEN(f_len),
    .fifo_ARSIZE(f_size), .fifo_ARBURST(f_burst),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
    .pending_cnt(pending_cnt), .grant_idx(grant_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t        fq[4][$];
  logic [46:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  pop_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic ent_t mk(input int m, input int s);
    ent_t e;
    e.id    = 4'(m*3 + s + 1);
    e.addr  = 32'h1000_0000 + 32'(m)*32'h100 + 32'(s)*32'h10;
    e.len   = 4'(m + s);
    e.size  = 3'(m);
    e.burst = 2'(s % 3);
    return e;
  endfunction

  function automatic logic [46:0] rec();
    return {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S};
  endfunction

  // Expected slave-side record is {master index, front entry}.
  task automatic epush(input int m, input ent_t e);
    exp_q.push_back({2'(m), e});
  endtask

  task automatic drive();
    for (int m = 0; m < 4; m++) begin
      if (fq[m].size() > 0) begin
        fifo_empty[m] = 1'b0;
        f_id[m] = fq[m][0].id;     f_addr[m]  = fq[m][0].addr;
        f_len[m] = fq[m][0].len;   f_size[m]  = fq[m][0].size;
        f_burst[m] = fq[m][0].burst;
      end else begin
        fifo_empty[m] = 1'b1;
        f_id[m] = '0; f_addr[m] = '0; f_len[m] = '0; f_size[m] = '0; f_burst[m] = '0;
      end
    end
  endtask

  // Called at the negedge: settle, scoreboard any handshake due at the next
  // posedge, advance popped FIFO models after the edge, return at the negedge.
  task automatic cyc();
    logic [46:0] e;
    #1;
    pop_s = fifo_pop;
    if (ARVALID_S && ARREADY_S) begin
      if (exp_q.size() == 0) chk("sb_unexpected_ar", 64'(exp_q.size()), 64'(1));
      else begin
        e = exp_q.pop_front();
        chk("sb_ar", 64'(rec()), 64'(e));
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++)
      if (pop_s[m] && fq[m].size() > 0) void'(fq[m].pop_front());
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int m = 0; m < 4; m++) fq[m].delete();
    exp_q.delete();
    drive();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] oh;
    ent_t       e2;
    rst = 1'b1; ARREADY_S = 1'b0; RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
    pop_s = '0;
    drive();
    @(negedge clk);
    do_reset();

    // Reset values, then idle with all FIFOs empty.
    chk("rst_arvalid", 64'(ARVALID_S), 64'(0));
    chk("rst_arid",    64'(ARID_S),    64'(0));
    chk("rst_araddr",  64'(ARADDR_S),  64'(0));
    chk("rst_gidx",    64'(grant_idx), 64'(0));
    for (int i = 0; i < 10; i++) begin
      chk("idle_arvalid", 64'(ARVALID_S),   64'(0));
      chk("idle_pop",     64'(fifo_pop),    64'(0));
      chk("idle_pending", 64'(pending_cnt), 64'(0));
      cyc();
    end

    // Single request from master 2.
    ARREADY_S = 1'b1;
    e2.id = 4'h5; e2.addr = 32'h1000; e2.len = 4'd3; e2.size = 3'd2; e2.burst = 2'd1;
    fq[2].push_back(e2); epush(2, e2); drive();
    #1;
    chk("m2_pop",     64'(fifo_pop),  64'(4'b0100));
    chk("m2_novalid", 64'(ARVALID_S), 64'(0));
    cyc();
    chk("m2_valid",  64'(ARVALID_S), 64'(1));
    chk("m2_arid",   64'(ARID_S),    64'(6'b10_0101));
    chk("m2_araddr", 64'(ARADDR_S),  64'(32'h1000));
    chk("m2_gidx",   64'(grant_idx), 64'(2));
    cyc();
    chk("m2_done", 64'(ARVALID_S), 64'(0));

    // All masters busy: strict rotation, one AR per cycle.
    do_reset();
    ARREADY_S = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int m = 0; m < 4; m++) begin fq[m].push_back(mk(m, s)); epush(m, mk(m, s)); end
    drive();
    for (int k = 0; k < 8; k++) begin
      #1;
      oh = '0; oh[k % 4] = 1'b1;
      chk("rr_pop", 64'(fifo_pop), 64'(oh));
      cyc();
      chk("rr_valid", 64'(ARVALID_S), 64'(1));
      chk("rr_gidx",  64'(grant_idx), 64'(k % 4));
    end
    #1;
    chk("rr_nopop", 64'(fifo_pop), 64'(0));
    cyc();
    chk("rr_idle", 64'(ARVALID_S), 64'(0));

    // Back-pressure: held request stable, no pops, regrant on the ready cycle.
    do_reset();
    ARREADY_S = 1'b0;
    fq[1].push_back(mk(1, 0)); fq[1].push_back(mk(1, 1)); fq[3].push_back(mk(3, 0));
    epush(1, mk(1, 0)); epush(3, mk(3, 0)); epush(1, mk(1, 1));
    drive();
    #1;
    chk("st_pop1", 64'(fifo_pop), 64'(4'b0010));
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("st_valid", 64'(ARVALID_S), 64'(1));
      chk("st_hold",  64'(rec()),     64'({2'd1, mk(1, 0)}));
      chk("st_nopop", 64'(fifo_pop),  64'(0));
      cyc();
    end
    ARREADY_S = 1'b1;
    #1;
    chk("st_regrant", 64'(fifo_pop), 64'(4'b1000));
    cyc();
    chk("st_gidx3", 64'(grant_idx), 64'(3));
    #1;
    chk("st_pop_m1", 64'(fifo_pop), 64'(4'b0010));
    cyc();
    chk("st_gidx1", 64'(grant_idx), 64'(1));
    cyc();
    chk("st_idle", 64'(ARVALID_S), 64'(0));

    // Outstanding-read limit.
    do_reset();
    ARREADY_S = 1'b1;
    for (int m = 0; m < 3; m++) begin fq[m].push_back(mk(m, 2)); epush(m, mk(m, 2)); end
    drive();
`ifdef AR_XBAR_ARB_PENDING_LIMIT_EN
    #1;
    chk("lim_pop0", 64'(fifo_pop), 64'(4'b0001));
    cyc();
    chk("lim_pend1", 64'(pending_cnt), 64'(1));
    #1;
    chk("lim_pop1", 64'(fifo_pop), 64'(4'b0010));
    cyc();
    chk("lim_pend2", 64'(pending_cnt), 64'(2));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lim_block", 64'(fifo_pop), 64'(0));
      cyc();
    end
    chk("lim_pend2b", 64'(pending_cnt), 64'(2));
    RVALID_S = 1'b1; RREADY_S = 1'b1; RLAST_S = 1'b1;
    #1;
    chk("lim_nobypass", 64'(fifo_pop), 64'(0));
    cyc();
    RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
    chk("lim_pend_dec", 64'(pending_cnt), 64'(1));
    #1;
    chk("lim_pop2", 64'(fifo_pop), 64'(4'b0100));
    cyc();
    chk("lim_pend_re", 64'(pending_cnt), 64'(2));
    chk("lim_gidx",    64'(grant_idx),   64'(2));
    RVALID_S = 1'b1; RREADY_S = 1'b1; RLAST_S = 1'b1;
    cyc(); cyc(); cyc();
    RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
    chk("lim_floor", 64'(pending_cnt), 64'(0));
`else
    for (int k = 0; k < 3; k++) begin
      #1;
      oh = '0; oh[k] = 1'b1;
      chk("nolim_pop", 64'(fifo_pop), 64'(oh));
      cyc();
      chk("nolim_pend", 64'(pending_cnt), 64'(0));
    end
    RVALID_S = 1'b1; RREADY_S = 1'b1; RLAST_S = 1'b1;
    cyc();
    RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
    chk("nolim_pend_r", 64'(pending_cnt), 64'(0));
`endif
    cyc();
    chk("lim_idle", 64'(ARVALID_S), 64'(0));

    // Reset while a request is held: it is dropped; master 0 wins after.
    do_reset();
    ARREADY_S = 1'b0;
    fq[2].push_back(mk(2, 2)); drive();
    #1;
    chk("mr_pop2", 64'(fifo_pop), 64'(4'b0100));
    cyc();
    chk("mr_valid", 64'(ARVALID_S), 64'(1));
    fq[3].push_back(mk(3, 3)); fq[0].push_back(mk(0, 3)); drive();
    cyc();
    rst = 1'b1;
    #1;
    chk("mr_arvalid", 64'(ARVALID_S), 64'(0));
    chk("mr_arid",    64'(ARID_S),    64'(0));
    chk("mr_gidx",    64'(grant_idx), 64'(0));
    chk("mr_nopop",   64'(fifo_pop),  64'(0));
    cyc();
    chk("mr_nopop2", 64'(fifo_pop), 64'(0));
    rst = 1'b0;
    ARREADY_S = 1'b1;
    epush(0, mk(0, 3)); epush(3, mk(3, 3));
    #1;
    chk("mr_first", 64'(fifo_pop), 64'(4'b0001));
    cyc();
    chk("mr_gidx0", 64'(grant_idx), 64'(0));
    #1;
    chk("mr_second", 64'(fifo_pop), 64'(4'b1000));
    cyc();
    cyc();
    chk("mr_idle",  64'(ARVALID_S),    64'(0));
    chk("sb_drain", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
